// File: rtl/game_tick_gen.sv
// Snake move-tick generator: syncs slow_clk, prescales by speed level, gates by game state.
// Optional TICK_OVERRUN_CNT_EN adds a saturating 8-bit overrun_cnt output.
module game_tick_gen #(
    parameter int BASE_DIV  = 8,
    parameter int MIN_DIV   = 2,
    parameter int STEP      = 1,
    parameter int MAX_LEVEL = 6,
    parameter int LVL_W     = 3
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             slow_clk,
    input  logic             start,
    input  logic             pause_toggle,
    input  logic             game_over,
    input  logic             speed_up,
    input  logic             tick_ready,
    output logic             tick_valid,
    output logic             overrun,
    output logic [LVL_W-1:0] speed_level,
    output logic [1:0]       state
`ifdef TICK_OVERRUN_CNT_EN
    ,
    output logic [7:0]       overrun_cnt
`endif
);

    localparam int CNT_W = $clog2(BASE_DIV) + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10,
        ST_OVER   = 2'b11
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_s1;
    logic               r_s2;
    logic               r_s3;
    logic               w_base_tick;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [LVL_W-1:0]   r_level;
    logic [LVL_W-1:0]   w_level_next;
    logic               r_tick_valid;
    logic               w_tick_valid_next;
    logic               r_overrun;
    logic               w_overrun_next;
    logic               w_gen_tick;
    logic               w_kill_tick;
    logic               w_start_run;
    logic signed [31:0] w_level_s;
    logic signed [31:0] w_reload_raw;
    logic signed [31:0] w_reload;
    logic [CNT_W-1:0]   w_reload_m1;

    assign w_base_tick = r_s2 & ~r_s3;

    // Signed arithmetic so a large level clamps to MIN_DIV instead of wrapping.
    assign w_level_s    = signed'(32'(r_level));
    assign w_reload_raw = BASE_DIV - (w_level_s * STEP);
    assign w_reload     = (w_reload_raw < MIN_DIV) ? MIN_DIV : w_reload_raw;
    assign w_reload_m1  = CNT_W'(w_reload - 1);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_level_next = r_level;
        w_gen_tick   = 1'b0;
        w_kill_tick  = 1'b0;
        w_start_run  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = '0;
                    w_level_next = '0;
                    w_start_run  = 1'b1;
                end
            end
            ST_RUN: begin
                if (game_over) begin
                    w_state_next = ST_OVER;
                    w_kill_tick  = 1'b1;
                end else if (pause_toggle) begin
                    w_state_next = ST_PAUSED;
                end else begin
                    if (speed_up && (r_level < LVL_W'(MAX_LEVEL))) begin
                        w_level_next = r_level + 1'b1;
                    end
                    // '>=' lets a shrinking reload terminate an already-long period.
                    if (w_base_tick) begin
                        if (r_cnt >= w_reload_m1) begin
                            w_cnt_next = '0;
                            w_gen_tick = 1'b1;
                        end else begin
                            w_cnt_next = r_cnt + 1'b1;
                        end
                    end
                end
            end
            ST_PAUSED: begin
                if (game_over) begin
                    w_state_next = ST_OVER;
                    w_kill_tick  = 1'b1;
                end else if (pause_toggle) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_kill_tick = 1'b1;
                if (start) begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = '0;
                    w_level_next = '0;
                    w_start_run  = 1'b1;
                end
            end
        endcase
    end

    // A new tick while one is still pending is coalesced and flagged.
    always_comb begin
        w_overrun_next = w_gen_tick & r_tick_valid & ~tick_ready;
        if (w_kill_tick) begin
            w_tick_valid_next = 1'b0;
        end else if (w_gen_tick) begin
            w_tick_valid_next = 1'b1;
        end else if (r_tick_valid && tick_ready) begin
            w_tick_valid_next = 1'b0;
        end else begin
            w_tick_valid_next = r_tick_valid;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_s3         <= 1'b0;
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_level      <= '0;
            r_tick_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_s1         <= slow_clk;
            r_s2         <= r_s1;
            r_s3         <= r_s2;
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_level      <= w_level_next;
            r_tick_valid <= w_tick_valid_next;
            r_overrun    <= w_overrun_next;
        end
    end

`ifdef TICK_OVERRUN_CNT_EN
    logic [7:0] r_overrun_cnt;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_overrun_cnt <= '0;
        end else if (w_start_run) begin
            r_overrun_cnt <= '0;
        end else if (w_overrun_next && (r_overrun_cnt != 8'hFF)) begin
            r_overrun_cnt <= r_overrun_cnt + 8'd1;
        end
    end

    assign overrun_cnt = r_overrun_cnt;
`endif

    assign tick_valid  = r_tick_valid;
    assign overrun     = r_overrun;
    assign speed_level = r_level;
    assign state       = r_state;

endmodule
